oam_dma: RTL and testbench

Sprite OAM DMA engine between the CPU core and the PPU on the CPU address/data bus. A CPU write to the DMA page register starts the transfer. The engine stalls the CPU through `rdy` and takes over the bus. It then copies 256 bytes from CPU page `$XX00–$XXFF` into the PPU OAM data port (`$2004`) as alternating read/write cycles. The top level muxes `dma_addr`/`dma_rw`/`dma_data` onto `cpu_addr_bus`/`rw`/`cpu_data_bus` while `dma_active` is high.

---
 rtl/oam_dma_if.sv | 24 ++
 rtl/oam_dma.sv | 140 ++++++++++++++
 tb/tb_oam_dma.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// CPU-side bus bundle for the sprite OAM DMA engine: core request signals in,
// stall/bus-takeover signals out. The engine connects through the slave modport.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic [7:0]  bus_rdata;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_data;
  logic [9:0]  busy_cycles;

  modport master (
    output cpu_addr, cpu_wdata, cpu_rw, bus_rdata,
    input  rdy, dma_active, dma_addr, dma_rw, dma_data, busy_cycles
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rw, bus_rdata,
    output rdy, dma_active, dma_addr, dma_rw, dma_data, busy_cycles
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a write to the page register stalls the CPU (rdy low the cycle after) and copies
// XFER_LEN bytes to the OAM port as read/write pairs. OAM_DMA_ODD_ALIGN_EN adds the odd-cycle ALIGN state.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        reset,
  oam_dma_if.slave    bus
);

`ifdef OAM_DMA_ODD_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t      r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_data_q;
  logic [9:0]  r_busy_cycles;
  logic        r_rdy;
  logic        r_dma_active;
  logic [15:0] r_dma_addr;
  logic        r_dma_rw;
  logic [7:0]  r_dma_data;
`ifdef OAM_DMA_ODD_ALIGN_EN
  logic        r_cyc_par;
`endif

  logic       w_trigger;
  logic       w_last;
  logic [7:0] w_idx_nxt;

  assign w_trigger = (bus.cpu_rw == 1'b0) && (bus.cpu_addr == DMA_REG_ADDR);
  assign w_last    = (r_idx == LAST_IDX);
  assign w_idx_nxt = r_idx + 8'd1;

  // Bus outputs are registered alongside the state so they always describe the current cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_page        <= 8'h00;
      r_idx         <= 8'h00;
      r_data_q      <= 8'h00;
      r_busy_cycles <= 10'd0;
      r_rdy         <= 1'b1;
      r_dma_active  <= 1'b0;
      r_dma_addr    <= 16'h0000;
      r_dma_rw      <= 1'b1;
      r_dma_data    <= 8'h00;
`ifdef OAM_DMA_ODD_ALIGN_EN
      r_cyc_par     <= 1'b0;
`endif
    end else begin
`ifdef OAM_DMA_ODD_ALIGN_EN
      r_cyc_par <= ~r_cyc_par;
`endif
      if (r_state != IDLE && r_busy_cycles != 10'h3FF)
        r_busy_cycles <= r_busy_cycles + 10'd1;

      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_page        <= bus.cpu_wdata;
            r_idx         <= 8'h00;
            r_busy_cycles <= 10'd0;
            r_rdy         <= 1'b0;
            r_state       <= HALT;
          end
        end
        HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
          if (r_cyc_par) begin
            r_state <= ALIGN;
          end else begin
            r_state      <= READ;
            r_dma_active <= 1'b1;
            r_dma_rw     <= 1'b1;
            r_dma_addr   <= {r_page, r_idx};
            r_dma_data   <= 8'h00;
          end
`else
          r_state      <= READ;
          r_dma_active <= 1'b1;
          r_dma_rw     <= 1'b1;
          r_dma_addr   <= {r_page, r_idx};
          r_dma_data   <= 8'h00;
`endif
        end
`ifdef OAM_DMA_ODD_ALIGN_EN
        ALIGN: begin
          r_state      <= READ;
          r_dma_active <= 1'b1;
          r_dma_rw     <= 1'b1;
          r_dma_addr   <= {r_page, r_idx};
          r_dma_data   <= 8'h00;
        end
`endif
        READ: begin
          r_data_q   <= bus.bus_rdata;
          r_state    <= WRITE;
          r_dma_rw   <= 1'b0;
          r_dma_addr <= OAM_DATA_ADDR;
          r_dma_data <= bus.bus_rdata;
        end
        WRITE: begin
          if (w_last) begin
            r_state      <= IDLE;
            r_rdy        <= 1'b1;
            r_dma_active <= 1'b0;
            r_dma_rw     <= 1'b1;
            r_dma_addr   <= 16'h0000;
            r_dma_data   <= 8'h00;
          end else begin
            // Only the low byte advances, so page $FF never carries past $FFFF.
            r_idx      <= w_idx_nxt;
            r_state    <= READ;
            r_dma_rw   <= 1'b1;
            r_dma_addr <= {r_page, w_idx_nxt};
            r_dma_data <= 8'h00;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdy         = r_rdy;
  assign bus.dma_active  = r_dma_active;
  assign bus.dma_addr    = r_dma_addr;
  assign bus.dma_rw      = r_dma_rw;
  assign bus.dma_data    = r_dma_data;
  assign bus.busy_cycles = r_busy_cycles;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: vector table for idle-bus decoding, directed corner sequences and
// randomized transfers checked against a per-transfer byte-copy reference.
module tb_oam_dma;
  localparam int XL   = 256;
  localparam int XCYC = 1 + 2 * XL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  oam_dma_if bus_if ();

  oam_dma #(.DMA_REG_ADDR(16'h4014), .OAM_DATA_ADDR(16'h2004), .XFER_LEN(XL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] wq[$];
  logic [15:0] rq[$];
  int bad_wr_addr = 0;
  int checks = 0;
  int failures = 0;

  always_comb begin
    bus_if.bus_rdata = (bus_if.dma_active && bus_if.dma_rw) ? mem[bus_if.dma_addr] : 8'hEE;
  end

  // Bus observer: records every DMA read address and every OAM write byte.
  always @(negedge clk) begin
    if (!reset && bus_if.dma_active) begin
      if (bus_if.dma_rw) rq.push_back(bus_if.dma_addr);
      else begin
        wq.push_back(bus_if.dma_data);
        if (bus_if.dma_addr != 16'h2004) bad_wr_addr++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_idle();
    bus_if.cpu_addr  = 16'h0000;
    bus_if.cpu_rw    = 1'b1;
    bus_if.cpu_wdata = 8'h00;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Full transfer from page pg; expectation is simply mem[pg*256 + i] for i in order.
  task automatic run_xfer(input logic [7:0] pg, input string tag);
    logic [7:0] expq[$];
    int lowcnt;
    int bad;
    bit done;
    for (int i = 0; i < XL; i++) expq.push_back(mem[{pg, 8'(i)}]);
    wq.delete();
    rq.delete();
    bad_wr_addr = 0;
    bus_if.cpu_addr  = 16'h4014;
    bus_if.cpu_rw    = 1'b0;
    bus_if.cpu_wdata = pg;
    tick();
    cpu_idle();
    check({tag, " rdy_fall"}, 32'(bus_if.rdy), 32'd0);
    lowcnt = 0;
    done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (bus_if.rdy) done = 1;
      else begin
        lowcnt++;
        tick();
      end
    end
    check({tag, " rdy_rise"}, 32'(bus_if.rdy), 32'd1);
    check({tag, " stall_len"}, lowcnt, XCYC);
    check({tag, " busy_cycles"}, 32'(bus_if.busy_cycles), XCYC);
    check({tag, " write_count"}, wq.size(), XL);
    check({tag, " read_count"}, rq.size(), XL);
    bad = 0;
    for (int i = 0; i < XL && i < wq.size(); i++) if (wq[i] !== expq[i]) bad++;
    check({tag, " write_data_errs"}, bad, 0);
    bad = 0;
    for (int i = 0; i < XL && i < rq.size(); i++) if (rq[i] !== {pg, 8'(i)}) bad++;
    check({tag, " read_addr_errs"}, bad, 0);
    check({tag, " oam_addr_errs"}, bad_wr_addr, 0);
    check({tag, " idle_addr"}, 32'(bus_if.dma_addr), 32'd0);
    check({tag, " idle_active"}, 32'(bus_if.dma_active), 32'd0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic        exp_rdy;
  } vec_t;

  initial begin
    vec_t vt[6];
    logic [7:0] pg;
    int gap;

    vt[0] = '{16'h4014, 1'b1, 8'h02, 1'b1};
    vt[1] = '{16'h4015, 1'b0, 8'h02, 1'b1};
    vt[2] = '{16'h2004, 1'b0, 8'h33, 1'b1};
    vt[3] = '{16'h0000, 1'b1, 8'h00, 1'b1};
    vt[4] = '{16'h4014, 1'b0, 8'h07, 1'b0};
    vt[5] = '{16'hC014, 1'b0, 8'h07, 1'b1};

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    cpu_idle();
    tick();
    tick();
    reset = 1'b0;
    check("reset rdy", 32'(bus_if.rdy), 32'd1);
    check("reset active", 32'(bus_if.dma_active), 32'd0);
    check("reset addr", 32'(bus_if.dma_addr), 32'd0);
    check("reset rw", 32'(bus_if.dma_rw), 32'd1);
    check("reset data", 32'(bus_if.dma_data), 32'd0);
    check("reset busy", 32'(bus_if.busy_cycles), 32'd0);

    for (int v = 0; v < 6; v++) begin
      bus_if.cpu_addr  = vt[v].addr;
      bus_if.cpu_rw    = vt[v].rw;
      bus_if.cpu_wdata = vt[v].wdata;
      tick();
      cpu_idle();
      check($sformatf("vec%0d rdy", v), 32'(bus_if.rdy), 32'(vt[v].exp_rdy));
      check($sformatf("vec%0d active", v), 32'(bus_if.dma_active), 32'd0);
      tick();
      check($sformatf("vec%0d rdy2", v), 32'(bus_if.rdy), 32'(vt[v].exp_rdy));
      pulse_reset();
    end

    // Trigger coincident with reset: reset wins.
    bus_if.cpu_addr  = 16'h4014;
    bus_if.cpu_rw    = 1'b0;
    bus_if.cpu_wdata = 8'h02;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_idle();
    check("rst_vs_trig rdy", 32'(bus_if.rdy), 32'd1);
    tick();
    check("rst_vs_trig rdy2", 32'(bus_if.rdy), 32'd1);

    run_xfer(8'h02, "page02");
    run_xfer(8'hFF, "pageFF");
    check("pageFF last_read", (rq.size() == XL) ? 32'(rq[XL-1]) : 32'hDEAD, 32'hFFFF);

    // Reset during WRITE of idx 100.
    wq.delete();
    bus_if.cpu_addr  = 16'h4014;
    bus_if.cpu_rw    = 1'b0;
    bus_if.cpu_wdata = 8'h05;
    tick();
    cpu_idle();
    for (int c = 0; c < 202; c++) tick();
    check("midrst in_write rw", 32'(bus_if.dma_rw), 32'd0);
    check("midrst in_write addr", 32'(bus_if.dma_addr), 32'h2004);
    check("midrst writes_before", wq.size(), 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst rdy", 32'(bus_if.rdy), 32'd1);
    check("midrst active", 32'(bus_if.dma_active), 32'd0);
    check("midrst busy", 32'(bus_if.busy_cycles), 32'd0);
    check("midrst addr", 32'(bus_if.dma_addr), 32'd0);
    tick();
    check("midrst stays idle", 32'(bus_if.dma_active), 32'd0);
    run_xfer(8'h05, "after_rst");

    // Back-to-back: second trigger in the very cycle rdy rises.
    run_xfer(8'h03, "b2b_03");
    run_xfer(8'h04, "b2b_04");

    // Randomized transfers with CPU noise between them.
    for (int r = 0; r < 6; r++) begin
      gap = $urandom_range(1, 12);
      for (int g = 0; g < gap; g++) begin
        bus_if.cpu_addr  = 16'($urandom);
        bus_if.cpu_rw    = 1'($urandom);
        bus_if.cpu_wdata = 8'($urandom);
        if (bus_if.cpu_addr == 16'h4014) bus_if.cpu_addr = 16'h4015;
        tick();
        check($sformatf("rand%0d noise rdy", r), 32'(bus_if.rdy), 32'd1);
      end
      cpu_idle();
      pg = 8'($urandom);
      run_xfer(pg, $sformatf("rand%0d pg%02h", r, pg));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
